// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
// Chooses the next PC from four sources: sequential, branch, jalr or trap.
// A redirect that arrives during a fetch stall is held and applied on release.
// Misaligned branch/jalr targets are turned into a trap to TRAP_VECTOR.
module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           INSTR_BYTES  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(32'h0000_0100)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [1:0]            pc_src,
  input  logic [ADDR_WIDTH-1:0] imm_op,
  input  logic [ADDR_WIDTH-1:0] rs1_val,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus,
  output logic                  flush,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] bad_addr
);

  // INSTR_BYTES is a power of two, so its low bits form the alignment mask
  localparam logic [ADDR_WIDTH-1:0] INCR       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = INCR - ADDR_WIDTH'(1);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JALR   = 2'b10;
  localparam logic [1:0] SRC_TRAP   = 2'b11;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [ADDR_WIDTH-1:0] pending_target_q, pending_target_d;
  logic                  pending_mis_q, pending_mis_d;
  logic [ADDR_WIDTH-1:0] bad_addr_q, bad_addr_d;
  logic                  flush_q, flush_d;
  logic                  misaligned_q, misaligned_d;

  logic [ADDR_WIDTH-1:0] branch_sum;
  logic [ADDR_WIDTH-1:0] jalr_sum;
  logic [ADDR_WIDTH-1:0] target_raw;
  logic [ADDR_WIDTH-1:0] target_eff;
  logic                  redirect;
  logic                  target_mis;

  // Raw redirect target, alignment check and the trap-substituted target
  always_comb begin
    branch_sum = pc_q + imm_op;
    jalr_sum   = rs1_val + imm_op;
    redirect   = (pc_src != SRC_SEQ);
    target_raw = branch_sum;
    target_mis = 1'b0;
    case (pc_src)
      SRC_BRANCH: begin
        target_raw = branch_sum;
        target_mis = ((target_raw & ALIGN_MASK) != '0);
      end
      SRC_JALR: begin
        target_raw = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
        target_mis = ((target_raw & ALIGN_MASK) != '0);
      end
      SRC_TRAP: begin
        target_raw = TRAP_VECTOR;
        target_mis = 1'b0;
      end
      default: begin
        target_raw = branch_sum;
        target_mis = 1'b0;
      end
    endcase
    target_eff = target_mis ? TRAP_VECTOR : target_raw;
  end

  // Next-state selection: a live redirect beats a held one, which beats sequential
  always_comb begin
    pc_d             = pc_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    pending_mis_d    = pending_mis_q;
    bad_addr_d       = bad_addr_q;
    flush_d          = 1'b0;
    misaligned_d     = 1'b0;
    if (!stall) begin
      if (redirect) begin
        pc_d            = target_eff;
        pending_valid_d = 1'b0;
        pending_mis_d   = 1'b0;
        flush_d         = 1'b1;
        misaligned_d    = target_mis;
        if (target_mis) begin
          bad_addr_d = target_raw;
        end
      end else if (pending_valid_q) begin
        pc_d            = pending_target_q;
        pending_valid_d = 1'b0;
        pending_mis_d   = 1'b0;
        flush_d         = 1'b1;
        misaligned_d    = pending_mis_q;
      end else begin
        pc_d = pc_q + INCR;
      end
    end else if (redirect) begin
      pending_valid_d  = 1'b1;
      pending_target_d = target_eff;
      pending_mis_d    = target_mis;
      if (target_mis) begin
        bad_addr_d = target_raw;
      end
    end
  end

  // State registers; reset discards any held redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q             <= RESET_VECTOR;
      pending_valid_q  <= 1'b0;
      pending_target_q <= '0;
      pending_mis_q    <= 1'b0;
      bad_addr_q       <= '0;
      flush_q          <= 1'b0;
      misaligned_q     <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
      pending_mis_q    <= pending_mis_d;
      bad_addr_q       <= bad_addr_d;
      flush_q          <= flush_d;
      misaligned_q     <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign pc_plus    = pc_q + INCR;
  assign flush      = flush_q;
  assign misaligned = misaligned_q;
  assign bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer (32-bit, 4-byte instructions).
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] imm_op;
  logic [31:0] rs1_val;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        flush;
  logic        misaligned;
  logic [31:0] bad_addr;

  int total_count = 0;
  int bad_count   = 0;

  pc_sequencer #(
    .ADDR_WIDTH  (32),
    .INSTR_BYTES (4),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .pc_src    (pc_src),
    .imm_op    (imm_op),
    .rs1_val   (rs1_val),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .flush     (flush),
    .misaligned(misaligned),
    .bad_addr  (bad_addr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_count++;
    if (got !== exp) begin
      bad_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then let one rising edge pass and settle
  task automatic applyStimulus(input logic s, input logic [1:0] src,
                               input logic [31:0] imm, input logic [31:0] rs1);
    stall   = s;
    pc_src  = src;
    imm_op  = imm;
    rs1_val = rs1;
    @(posedge clk);
    #1;
  endtask

  // Check pc, flush and misaligned together after an edge
  task automatic checkState(input string tag, input logic [31:0] exp_pc,
                            input logic exp_flush, input logic exp_mis);
    checkOutput({tag, "_pc"}, pc, exp_pc);
    checkOutput({tag, "_flush"}, {31'b0, flush}, {31'b0, exp_flush});
    checkOutput({tag, "_mis"}, {31'b0, misaligned}, {31'b0, exp_mis});
  endtask

  // Directed sequence with hand-computed expectations
  initial begin
    rst     = 1'b1;
    stall   = 1'b0;
    pc_src  = 2'b00;
    imm_op  = '0;
    rs1_val = '0;
    #2 rst = 1'b0;
    #1;
    checkState("reset", 32'h0, 1'b0, 1'b0);
    checkOutput("reset_bad", bad_addr, 32'h0);
    checkOutput("reset_pcplus", pc_plus, 32'h4);
    #19 rst = 1'b1;

    // Sequential fetch from reset vector
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("seq1", 32'h4, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("seq2", 32'h8, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("seq3", 32'hC, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("seq4", 32'h10, 1'b0, 1'b0);

    // Backward branch from 0x10 by -8
    applyStimulus(1'b0, 2'b01, 32'hFFFF_FFF8, 32'h0);
    checkState("branch", 32'h8, 1'b1, 1'b0);
    checkOutput("branch_pcplus", pc_plus, 32'hC);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("branch_after", 32'hC, 1'b0, 1'b0);

    // JALR clears bit 0; a target with bit 1 set traps
    applyStimulus(1'b0, 2'b10, 32'h0, 32'h201);
    checkState("jalr", 32'h200, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b10, 32'h0, 32'h202);
    checkState("jalr_mis", 32'h100, 1'b1, 1'b1);
    checkOutput("jalr_mis_bad", bad_addr, 32'h202);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("jalr_after", 32'h104, 1'b0, 1'b0);
    checkOutput("bad_hold", bad_addr, 32'h202);

    // Misaligned branch: 0x104 + 2
    applyStimulus(1'b0, 2'b01, 32'h2, 32'h0);
    checkState("br_mis", 32'h100, 1'b1, 1'b1);
    checkOutput("br_mis_bad", bad_addr, 32'h106);

    // Explicit trap request
    applyStimulus(1'b0, 2'b11, 32'h0, 32'h0);
    checkState("trap", 32'h100, 1'b1, 1'b0);

    // Redirect presented during a 3-cycle stall, applied on release
    applyStimulus(1'b0, 2'b10, 32'h0, 32'h20);
    checkState("to20", 32'h20, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 32'h40, 32'h0);
    checkState("stall1", 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h0);
    checkState("stall2", 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h0);
    checkState("stall3", 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("release", 32'h60, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("release_after", 32'h64, 1'b0, 1'b0);

    // Misaligned redirect during stall: bad_addr updates at capture, trap on release
    applyStimulus(1'b1, 2'b01, 32'h2, 32'h0);
    checkState("pmis_cap", 32'h64, 1'b0, 1'b0);
    checkOutput("pmis_bad", bad_addr, 32'h66);
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h0);
    checkState("pmis_hold", 32'h64, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("pmis_rel", 32'h100, 1'b1, 1'b1);

    // New redirect on the release cycle beats the held one
    applyStimulus(1'b1, 2'b01, 32'h10, 32'h0);
    checkState("new_cap", 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b10, 32'h0, 32'h300);
    checkState("new_wins", 32'h300, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("new_after", 32'h304, 1'b0, 1'b0);

    // Sequential wrap at the top of the address space
    applyStimulus(1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);
    checkState("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    checkOutput("top_pcplus", pc_plus, 32'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("wrap", 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("wrap_seq", 32'h4, 1'b0, 1'b0);

    // Asynchronous reset between edges discards a pending redirect
    applyStimulus(1'b1, 2'b01, 32'h80, 32'h0);
    checkState("ar_cap", 32'h4, 1'b0, 1'b0);
    stall  = 1'b0;
    pc_src = 2'b00;
    #2 rst = 1'b0;
    #1;
    checkState("ar_now", 32'h0, 1'b0, 1'b0);
    checkOutput("ar_bad", bad_addr, 32'h0);
    #1 rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("ar_rel", 32'h4, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkState("ar_rel2", 32'h8, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
